// File: rtl/read_74hc165.sv
// rtl/read_74hc165.sv - reads a 74HC165 PISO chain into a parallel word with a one-cycle valid strobe
// Optional READ_74HC165_AUTO_SCAN_EN adds a free-running periodic scan trigger.
module read_74hc165 #(
    parameter int CHAIN_N = 1,
    parameter int CLK_DIV = 25
`ifdef READ_74HC165_AUTO_SCAN_EN
    ,
    parameter int SCAN_PERIOD = 50000
`endif
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   data_qh,
    output logic                   sh_ld_n,
    output logic                   clk_inh,
    output logic                   ser_clk,
    output logic [8*CHAIN_N-1:0]   data_out,
    output logic                   data_valid,
    output logic                   busy
);

    localparam int DATA_W = 8 * CHAIN_N;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [BIT_W-1:0]   bit_q;
    logic               phase_q;
    logic [DATA_W-1:0]  sr_q;
    logic               qh_meta_q;
    logic               qh_sync_q;
    logic               sh_ld_n_q;
    logic               clk_inh_q;
    logic               ser_clk_q;
    logic [DATA_W-1:0]  data_out_q;
    logic               data_valid_q;
    logic               busy_q;
    logic               scan_req;
    logic               div_last;
    logic               bit_last;

`ifdef READ_74HC165_AUTO_SCAN_EN
    localparam int SP_W = $clog2(SCAN_PERIOD);

    logic [SP_W-1:0] scan_cnt_q;
    logic            auto_start;

    // Keeps counting while a scan is running, so a trigger that lands on a busy reader is simply lost.
    assign auto_start = (scan_cnt_q == SP_W'(SCAN_PERIOD - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
        end else if (auto_start) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_q + SP_W'(1);
        end
    end

    assign scan_req = start | auto_start;
`else
    assign scan_req = start;
`endif

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_last = (bit_q == BIT_W'(DATA_W - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            phase_q      <= 1'b0;
            sr_q         <= '0;
            qh_meta_q    <= 1'b0;
            qh_sync_q    <= 1'b0;
            sh_ld_n_q    <= 1'b1;
            clk_inh_q    <= 1'b1;
            ser_clk_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            qh_meta_q    <= data_qh;
            qh_sync_q    <= qh_meta_q;
            data_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (scan_req) begin
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        sh_ld_n_q <= 1'b0;
                        div_q     <= '0;
                    end
                end
                LOAD: begin
                    if (div_last) begin
                        div_q     <= '0;
                        sh_ld_n_q <= 1'b1;
                        clk_inh_q <= 1'b0;
                        state_q   <= SETTLE;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                SETTLE: begin
                    if (div_last) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        phase_q <= 1'b0;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (!div_last) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!phase_q) begin
                            // Sample at the end of the low phase, just before the chips advance.
                            sr_q      <= {sr_q[DATA_W-2:0], qh_sync_q};
                            ser_clk_q <= 1'b1;
                            phase_q   <= 1'b1;
                        end else begin
                            ser_clk_q <= 1'b0;
                            phase_q   <= 1'b0;
                            if (bit_last) begin
                                clk_inh_q <= 1'b1;
                                state_q   <= DONE;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    data_out_q   <= sr_q;
                    data_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sh_ld_n    = sh_ld_n_q;
    assign clk_inh    = clk_inh_q;
    assign ser_clk    = ser_clk_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_read_74hc165.sv
// tb/tb_read_74hc165.sv - scoreboard bench for read_74hc165 (8-bit and 16-bit chains)
module tb_read_74hc165;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic [15:0] word;
        int          cyc;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        qh_noise = 1'b0;
    logic [7:0]  par0 = 8'h00;
    logic [7:0]  chip0 = 8'h00;
    logic [15:0] par1 = 16'h0000;
    logic [15:0] chip1 = 16'h0000;

    logic        sld0, inh0, sck0, dv0, bsy0;
    logic        sld1, inh1, sck1, dv1, bsy1;
    logic [7:0]  out0;
    logic [15:0] out1;

    logic [15:0] dout [2];
    logic        dv [2];
    logic        sld [2];
    logic        sck [2];
    logic        bsy [2];
    logic        inh [2];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    exp_t        e;
    int          low_cnt [2];
    int          rise_cnt [2];
    logic        prev_sck [2];
    logic        prev_dv [2];
    logic [15:0] last_out [2];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    read_74hc165 #(
        .CHAIN_N(1),
        .CLK_DIV(CLK_DIV)
`ifdef READ_74HC165_AUTO_SCAN_EN
        ,
        .SCAN_PERIOD(200)
`endif
    ) u_dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start0), .data_qh(chip0[7] ^ qh_noise),
        .sh_ld_n(sld0), .clk_inh(inh0), .ser_clk(sck0),
        .data_out(out0), .data_valid(dv0), .busy(bsy0)
    );

    read_74hc165 #(
        .CHAIN_N(2),
        .CLK_DIV(CLK_DIV)
`ifdef READ_74HC165_AUTO_SCAN_EN
        ,
        .SCAN_PERIOD(200)
`endif
    ) u_dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .start(start1), .data_qh(chip1[15] ^ qh_noise),
        .sh_ld_n(sld1), .clk_inh(inh1), .ser_clk(sck1),
        .data_out(out1), .data_valid(dv1), .busy(bsy1)
    );

    // Behavioural 74HC165 chains: asynchronous parallel load, shift toward QH on ser_clk rise.
    always @(posedge sck0 or negedge sld0) begin
        if (!sld0) chip0 <= par0;
        else if (!inh0) chip0 <= chip0 << 1;
    end

    always @(posedge sck1 or negedge sld1) begin
        if (!sld1) chip1 <= par1;
        else if (!inh1) chip1 <= chip1 << 1;
    end

    assign dout[0] = {8'h00, out0};
    assign dout[1] = out1;
    assign dv[0] = dv0;   assign dv[1] = dv1;
    assign sld[0] = sld0; assign sld[1] = sld1;
    assign sck[0] = sck0; assign sck[1] = sck1;
    assign bsy[0] = bsy0; assign bsy[1] = bsy1;
    assign inh[0] = inh0; assign inh[1] = inh1;

    function automatic string nm(input string s, input int d);
        return $sformatf("%s_%0d", s, d);
    endfunction

    function automatic int dw(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input int d);
        chk(nm("rst_sh_ld_n", d), 32'(sld[d]), 32'd1);
        chk(nm("rst_clk_inh", d), 32'(inh[d]), 32'd1);
        chk(nm("rst_ser_clk", d), 32'(sck[d]), 32'd0);
        chk(nm("rst_data_out", d), 32'(dout[d]), 32'd0);
        chk(nm("rst_data_valid", d), 32'(dv[d]), 32'd0);
        chk(nm("rst_busy", d), 32'(bsy[d]), 32'd0);
    endtask

    // Monitor: counts load pulses and shift edges, pops the scoreboard on every valid strobe.
    always @(negedge sys_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                low_cnt[d] = 0;
                rise_cnt[d] = 0;
                prev_sck[d] = 1'b0;
                prev_dv[d] = 1'b0;
                last_out[d] = 16'h0000;
            end else begin
                int sz;
                if (!sld[d]) low_cnt[d]++;
                if (sck[d] && !prev_sck[d]) rise_cnt[d]++;
                if (dv[d]) begin
                    chk(nm("valid_not_back_to_back", d), 32'(prev_dv[d]), 32'd0);
                    sz = (d == 0) ? sb0.size() : sb1.size();
                    chk(nm("valid_expected", d), 32'(sz != 0), 32'd1);
                    if (sz != 0) begin
                        if (d == 0) e = sb0.pop_front();
                        else e = sb1.pop_front();
                        chk(nm("data_out", d), 32'(dout[d]), 32'(e.word));
                        chk(nm("latency", d), 32'(cyc - e.cyc), 32'(2 * CLK_DIV * (dw(d) + 1) + 1));
                        chk(nm("load_low_cycles", d), 32'(low_cnt[d]), 32'(CLK_DIV));
                        chk(nm("ser_clk_rises", d), 32'(rise_cnt[d]), 32'(dw(d)));
                    end
                    low_cnt[d] = 0;
                    rise_cnt[d] = 0;
                end else begin
                    chk(nm("data_out_hold", d), 32'(dout[d]), 32'(last_out[d]));
                end
                prev_sck[d] = sck[d];
                prev_dv[d] = dv[d];
                last_out[d] = dout[d];
            end
        end
    end

    task automatic wait_idle(input int d);
        int n = 0;
        while (bsy[d] && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        chk(nm("scan_finished", d), 32'(n < 3000), 32'd1);
        repeat (3) @(posedge sys_clk);
    endtask

    task automatic do_scan(input int d, input logic [15:0] word, input bit collide);
        exp_t x;
        if (d == 0) par0 = word[7:0];
        else par1 = word;
        @(posedge sys_clk); #1;
        if (d == 0) start0 = 1'b1;
        else start1 = 1'b1;
        x.word = (d == 0) ? {8'h00, word[7:0]} : word;
        x.cyc = cyc + 1;
        if (d == 0) sb0.push_back(x);
        else sb1.push_back(x);
        @(posedge sys_clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        chk(nm("busy_after_start", d), 32'(bsy[d]), 32'd1);
        if (collide) begin
            repeat (18) @(posedge sys_clk);
            #1;
            if (d == 0) start0 = 1'b1;
            else start1 = 1'b1;
            @(posedge sys_clk); #1;
            start0 = 1'b0;
            start1 = 1'b0;
        end
        wait_idle(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (8) begin
            @(posedge sys_clk); #1;
            start0 = 1'($urandom);
            start1 = 1'($urandom);
            qh_noise = 1'($urandom);
        end
        start0 = 1'b0;
        start1 = 1'b0;
        qh_noise = 1'b0;
        @(negedge sys_clk);
        chk_reset(0);
        chk_reset(1);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;

`ifdef READ_74HC165_AUTO_SCAN_EN
        begin
            int rel;
            exp_t x;
            rel = cyc;
            for (int k = 1; k <= 3; k++) begin
                par0 = (k == 1) ? 8'h00 : (k == 2) ? 8'hFF : 8'($urandom);
                par1 = 16'($urandom);
                x.cyc = rel + 200 * k;
                x.word = {8'h00, par0};
                sb0.push_back(x);
                x.word = par1;
                sb1.push_back(x);
                while (cyc < rel + 200 * k + 150) @(posedge sys_clk);
            end
        end
`else
        do_scan(0, 16'h00A5, 1'b0);
        do_scan(1, 16'h3C81, 1'b0);
        do_scan(0, 16'h005A, 1'b1);

        // Abort a scan of 8'hFF during bit 3; its word must never appear.
        par0 = 8'hFF;
        @(posedge sys_clk); #1;
        start0 = 1'b1;
        sb0.push_back('{16'h00FF, cyc + 1});
        @(posedge sys_clk); #1;
        start0 = 1'b0;
        repeat (34) @(posedge sys_clk);
        #1;
        rst_n = 1'b0;
        sb0.delete();
        @(negedge sys_clk);
        chk_reset(0);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge sys_clk);
        do_scan(0, 16'h000F, 1'b0);

        for (int i = 0; i < 5; i++) begin
            do_scan(0, 16'($urandom), 1'b0);
            do_scan(1, 16'($urandom), 1'b0);
        end
`endif

        repeat (5) @(posedge sys_clk);
        chk("scoreboard_empty_0", 32'(sb0.size()), 32'd0);
        chk("scoreboard_empty_1", 32'(sb1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_74hc165.md
Name: read_74hc165

Overview:
- Reader-side companion to the 74HC595 output driver: reads a chain of 74HC165 parallel-in/serial-out shift registers (buttons, DIP switches) into a parallel word.
- Generates SH/LD_n, CLK_INH and the serial clock, samples QH, and presents the captured word with a one-cycle valid strobe.
- Sits between board-level input pins and user logic, in the same clock domain as the 595 driver.

Parameters:
- CHAIN_N, 1: number of cascaded 74HC165 chips. DATA_W = 8*CHAIN_N is a derived localparam.
- CLK_DIV, 25: sys_clk cycles per half-period of ser_clk. Legal values are >= 4.
- SCAN_PERIOD, 50000: sys_clk cycles between automatic scan starts. Used only when AUTO_SCAN_EN is defined.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle scan request.
- data_qh  in  1  QH serial output of the last chip in the chain (asynchronous pin).
- sh_ld_n  out  1  shift/load control to the chips; 0 = parallel load.
- clk_inh  out  1  clock inhibit to the chips; 1 = inhibited.
- ser_clk  out  1  shift clock to the chips; idles low.
- data_out  out  DATA_W  last captured word; bit DATA_W-1 is the first bit shifted out.
- data_valid  out  1  one-cycle pulse when data_out updates.
- busy  out  1  high from scan start until the DONE cycle, inclusive.

Behaviour:
- Reset values:
  - sh_ld_n=1, clk_inh=1, ser_clk=0.
  - data_out=0, data_valid=0, busy=0.
  - FSM=IDLE; all counters 0.
- Input synchronisation: data_qh passes through a 2-FF synchroniser. The shift logic uses only the synchronised value.
- FSM states: IDLE -> LOAD -> SETTLE -> SHIFT -> DONE -> IDLE.
  - IDLE: outputs at their idle values. start=1 sampled -> LOAD. busy goes high on the same edge.
  - LOAD: sh_ld_n=0 for exactly CLK_DIV cycles, then -> SETTLE.
  - SETTLE: sh_ld_n=1, clk_inh=0, ser_clk=0 for CLK_DIV cycles, then -> SHIFT. This gives QH time to settle on the first bit.
  - SHIFT: DATA_W bit periods. Each period has ser_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - On the last low-phase cycle, the synchronised QH is shifted into the LSB of the internal register (shift-left, MSB-first).
    - The rising ser_clk edge then advances the chips.
    - Bit counter is 0..DATA_W-1. After the high phase of the last bit -> DONE with ser_clk=0.
  - DONE, single cycle:
    - data_out <= shift register; data_valid=1.
    - clk_inh=1; busy drops on the next edge; then -> IDLE.
- Edge counts per scan: exactly DATA_W rising edges of ser_clk and exactly one sh_ld_n low pulse.
- Latency: data_valid is high in the cycle 2*CLK_DIV*(DATA_W+1)+1 edges after the edge that sampled start. CHAIN_N=1, CLK_DIV=4 gives edge 73.
- Output stability: data_out holds its value between DONE cycles. data_valid is never high for two consecutive cycles.
- start while busy: ignored, not queued. start in the DONE cycle is also ignored.
- Reset mid-operation: asynchronous return to the reset values above. The partial word is discarded and no data_valid is issued.
- Counter widths: sized with $clog2 of CLK_DIV, DATA_W and SCAN_PERIOD. No wrap occurs within a scan.

Optional Feature:
- Macro: READ_74HC165_AUTO_SCAN_EN.
- Defined:
  - A free-running counter issues an internal start every SCAN_PERIOD cycles, ORed with the start port.
  - First auto start occurs SCAN_PERIOD cycles after reset release.
  - If the scan is still busy when the counter expires, that trigger is dropped. The counter keeps running.
- Undefined: scans occur only on the start port. The counter is not instantiated.

Test Plan:
- Reset: hold rst_n=0 with toggling start and data_qh -> sh_ld_n=1, clk_inh=1, ser_clk=0, data_out=0, data_valid=0, busy=0.
- Single scan: CHAIN_N=1, CLK_DIV=4, behavioural 165 model loaded with 8'hA5, start pulse -> sh_ld_n low exactly 4 cycles, 8 ser_clk rising edges, data_valid one cycle at edge 73, data_out=8'hA5.
- Cascade: CHAIN_N=2, CLK_DIV=4, chips hold 16'h3C81 (first chip = high byte) -> 16 rising edges, data_out=16'h3C81, data_valid at edge 137.
- Busy collision: second start 20 cycles into a scan of 8'h5A -> exactly one data_valid pulse, data_out=8'h5A, no restart of sh_ld_n.
- Reset mid-shift: assert rst_n=0 during bit 3 of a scan of 8'hFF -> all outputs at reset values, no data_valid. A new scan of 8'h0F then yields data_out=8'h0F.
- Auto scan: READ_74HC165_AUTO_SCAN_EN defined, SCAN_PERIOD=200, CLK_DIV=4, input 8'h00 then 8'hFF -> data_valid pulses 200 cycles apart, and data_out follows the input on the next scan.
